sega_315_5011: RTL
==================

# sega_315_5011

Sprite attribute evaluator sitting on the sprite RAM data bus opposite the 315-5012 DMA sequencer. For each sprite it consumes the four attribute words that the sequencer presents (Y window, X/flip, pitch, row address). It answers the line-compare request, latches the drawing parameters for the line-buffer writer, and produces the per-line write-back address (address + pitch) that the sequencer stores back into sprite RAM.

## Interface
- No parameters; all widths fixed.
- i_MCLK  in  1  master clock; the only clock.
- i_RST  in  1  asynchronous, active-high reset.
- i_CLK5MNCEN  in  1  5 MHz clock enable; every register updates only on this enable.
- i_VPOS  in  8  line being evaluated.
- i_RD  in  16  sprite RAM read data.
- i_VCUL_n  in  1  step 0 strobe: i_RD = word0 {bottom[15:8], top[7:0]}.
- i_LOHP_n  in  1  step 1 strobe: i_RD = word1 {flip[15], unused[14:9], hpos[8:0]}.
- i_DELTAX_n  in  1  step 2 strobe: i_RD = word2, signed 16-bit pitch.
- i_ALULO_n  in  1  step 3 strobe: i_RD = word3, 16-bit row address.
- i_ONTRF  in  1  transfer / write-back phase.
- i_CWEN  in  1  write-back permitted.
- o_VEN_n  out  1  line match, low = sprite visible on i_VPOS.
- o_WD  out  16  write-back data (address + pitch).
- o_WDOE  out  1  o_WD valid / bus drive enable.
- o_OBJVALID  out  1  one-enable pulse: o_HPOS/o_FLIP/o_ADDR hold a new sprite.
- o_HPOS  out  9; o_FLIP  out  1; o_ADDR  out  16  latched drawing parameters.
- o_SEQERR  out  1  sticky protocol error.

## Operation
- Line compare (combinational): hit = (top <= i_VPOS) && (i_VPOS < bottom), unsigned. top == bottom, or bottom < top, never hits. o_VEN_n = ~(~i_VCUL_n & hit); high whenever i_VCUL_n is high.
- Sequencer FSM with states IDLE, GOT_Y, GOT_X, GOT_D, GOT_A. Transitions occur on enable only:
  - i_VCUL_n low, from any state: go to GOT_Y if hit, else IDLE. This step never errors.
  - i_LOHP_n low in GOT_Y: latch hpos and flip, go to GOT_X.
  - i_DELTAX_n low in GOT_X: latch pitch, go to GOT_D.
  - i_ALULO_n low in GOT_D: latch addr; compute next = addr + pitch modulo 2^16 (pitch sign-extended, carry discarded); go to GOT_A.
  - i_ONTRF high in GOT_A: on that enable, load o_HPOS/o_FLIP/o_ADDR from the latches, pulse o_OBJVALID for one enable period, go to IDLE.
- Out-of-order strobe (a strobe in any other state, or i_ONTRF outside GOT_A): no register update except o_SEQERR <= 1; state goes to IDLE.
- More than one of the four strobes low on the same enable is a protocol error; handle it as an out-of-order strobe. i_ONTRF high together with a strobe is also a protocol error.
- o_WDOE = i_ONTRF & i_CWEN & (state == GOT_A), combinational. o_WD = next register, always driven.
- o_SEQERR clears only on i_RST.

## Timing
- Reset values: state IDLE, all latches and o_HPOS/o_FLIP/o_ADDR/o_WD = 0, o_OBJVALID = 0, o_SEQERR = 0. o_VEN_n = 1 and o_WDOE = 0 while strobes are idle.
- o_VEN_n has zero-cycle latency from i_RD/i_VPOS/i_VCUL_n. The controller samples it in the same enable period.
- next is valid one enable after the i_ALULO_n strobe and stays stable through the whole GOT_A state.
- o_OBJVALID asserts on the enable that consumes i_ONTRF and deasserts on the following enable.
- Minimum sprite: 5 enables (steps 0-3 plus transfer). A non-hitting sprite costs 1 enable; a following i_VCUL_n is legal immediately.
- Asynchronous reset mid-sequence aborts it: o_WDOE drops immediately and no o_OBJVALID is produced.

## Structure
- Package sega_315_5011_pkg holds the state enum and the word field positions (TOP, BOTTOM, HPOS, FLIP msb/lsb).
- Sub-module sega_315_5011_linecmp: the combinational window compare (i_RD[15:0], i_VPOS → hit). Everything else stays in the top module.

## Test plan
- Hit: word0 = 0x2010, VPOS = 0x18; sequence word1 = 0x8123, word2 = 0x0040, word3 = 0x1000, then ONTRF + CWEN. Expect VEN_n = 0 at step 0; HPOS = 0x123, FLIP = 1, ADDR = 0x1000, one OBJVALID pulse; WD = 0x1040 with WDOE = 1 during transfer.
- Window edges with word0 = 0x2010: VPOS = 0x10 gives VEN_n = 0; VPOS = 0x20 gives VEN_n = 1. With word0 = 0x1010 and any VPOS, VEN_n = 1.
- Arithmetic wrap: word3 = 0xFFF0, pitch = 0x0020 gives WD = 0x0010. Pitch = 0xFFC0 with word3 = 0x0010 gives WD = 0xFFD0.
- Miss then hit: non-hitting VCUL directly followed by a hitting VCUL; the FSM reaches GOT_Y and SEQERR stays 0.
- Protocol errors, each run separately:
  - DELTAX_n strobe in GOT_Y.
  - VCUL_n and LOHP_n low together.
  - ONTRF in IDLE.
  Each gives SEQERR = 1, state IDLE, no OBJVALID, latches unchanged.
- Reset asserted in GOT_A with ONTRF and CWEN high: WDOE = 0 immediately; all outputs return to reset values; SEQERR = 0.

Source files
------------

// File: rtl/sega_315_5011_pkg.sv
// Shared types and sprite attribute word field positions for the 315-5011 evaluator.
package sega_315_5011_pkg;

   // Attribute fetch sequencer states
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StGotY = 3'd1,
      StGotX = 3'd2,
      StGotD = 3'd3,
      StGotA = 3'd4
   } seq_state_e;

   // Word 0: vertical window
   localparam int unsigned TopLsb    = 0;
   localparam int unsigned TopMsb    = 7;
   localparam int unsigned BottomLsb = 8;
   localparam int unsigned BottomMsb = 15;

   // Word 1: horizontal position and flip
   localparam int unsigned HposLsb = 0;
   localparam int unsigned HposMsb = 8;
   localparam int unsigned FlipLsb = 15;
   localparam int unsigned FlipMsb = 15;

endpackage

// File: rtl/sega_315_5011_linecmp.sv
// Combinational line-window compare: hit when top <= vpos < bottom (unsigned).
module sega_315_5011_linecmp
   import sega_315_5011_pkg::*;
(
   input  logic [15:0] i_RD,
   input  logic [7:0]  i_VPOS,
   output logic        o_HIT
);

   logic [7:0] w_top;
   logic [7:0] w_bottom;

   assign w_top    = i_RD[TopMsb:TopLsb];
   assign w_bottom = i_RD[BottomMsb:BottomLsb];

   // Empty or inverted windows fall out naturally: no vpos satisfies both bounds
   assign o_HIT = (w_top <= i_VPOS) && (i_VPOS < w_bottom);

endmodule

// File: rtl/sega_315_5011.sv
// Sprite attribute evaluator: line compare, attribute latching and write-back address.
module sega_315_5011
   import sega_315_5011_pkg::*;
(
   input  logic        i_MCLK,
   input  logic        i_RST,
   input  logic        i_CLK5MNCEN,
   input  logic [7:0]  i_VPOS,
   input  logic [15:0] i_RD,
   input  logic        i_VCUL_n,
   input  logic        i_LOHP_n,
   input  logic        i_DELTAX_n,
   input  logic        i_ALULO_n,
   input  logic        i_ONTRF,
   input  logic        i_CWEN,
   output logic        o_VEN_n,
   output logic [15:0] o_WD,
   output logic        o_WDOE,
   output logic        o_OBJVALID,
   output logic [8:0]  o_HPOS,
   output logic        o_FLIP,
   output logic [15:0] o_ADDR,
   output logic        o_SEQERR
);

   seq_state_e  r_state;
   logic [8:0]  r_hpos;
   logic        r_flip;
   logic [15:0] r_pitch;
   logic [15:0] r_addr;
   logic [15:0] r_next;
   logic        r_objvalid;
   logic [8:0]  r_out_hpos;
   logic        r_out_flip;
   logic [15:0] r_out_addr;
   logic        r_seqerr;

   logic        w_hit;
   logic        w_vcul;
   logic        w_lohp;
   logic        w_deltax;
   logic        w_alulo;
   logic [2:0]  w_nstb;
   logic        w_proto_err;

   sega_315_5011_linecmp u_linecmp (
      .i_RD   (i_RD),
      .i_VPOS (i_VPOS),
      .o_HIT  (w_hit)
   );

   assign w_vcul   = ~i_VCUL_n;
   assign w_lohp   = ~i_LOHP_n;
   assign w_deltax = ~i_DELTAX_n;
   assign w_alulo  = ~i_ALULO_n;

   // Decode simultaneous strobes: any overlap, or a transfer alongside a strobe, is illegal
   always_comb begin
      w_nstb      = 3'(w_vcul) + 3'(w_lohp) + 3'(w_deltax) + 3'(w_alulo);
      w_proto_err = (w_nstb > 3'd1) || (i_ONTRF && (w_nstb != 3'd0));
   end

   // Sequencer FSM with attribute latches and registered drawing outputs
   always_ff @(posedge i_MCLK or posedge i_RST) begin
      if (i_RST) begin
         r_state    <= StIdle;
         r_hpos     <= '0;
         r_flip     <= 1'b0;
         r_pitch    <= '0;
         r_addr     <= '0;
         r_next     <= '0;
         r_objvalid <= 1'b0;
         r_out_hpos <= '0;
         r_out_flip <= 1'b0;
         r_out_addr <= '0;
         r_seqerr   <= 1'b0;
      end else if (i_CLK5MNCEN) begin
         r_objvalid <= 1'b0;
         if (w_proto_err) begin
            r_seqerr <= 1'b1;
            r_state  <= StIdle;
         end else if (w_vcul) begin
            // Step 0 restarts from any state and is never an error
            r_state <= w_hit ? StGotY : StIdle;
         end else if (w_lohp) begin
            if (r_state == StGotY) begin
               r_hpos  <= i_RD[HposMsb:HposLsb];
               r_flip  <= i_RD[FlipMsb];
               r_state <= StGotX;
            end else begin
               r_seqerr <= 1'b1;
               r_state  <= StIdle;
            end
         end else if (w_deltax) begin
            if (r_state == StGotX) begin
               r_pitch <= i_RD;
               r_state <= StGotD;
            end else begin
               r_seqerr <= 1'b1;
               r_state  <= StIdle;
            end
         end else if (w_alulo) begin
            if (r_state == StGotD) begin
               r_addr  <= i_RD;
               // 16-bit wrap of the sum equals a sign-extended pitch add with carry dropped
               r_next  <= i_RD + r_pitch;
               r_state <= StGotA;
            end else begin
               r_seqerr <= 1'b1;
               r_state  <= StIdle;
            end
         end else if (i_ONTRF) begin
            if (r_state == StGotA) begin
               r_out_hpos <= r_hpos;
               r_out_flip <= r_flip;
               r_out_addr <= r_addr;
               r_objvalid <= 1'b1;
               r_state    <= StIdle;
            end else begin
               r_seqerr <= 1'b1;
               r_state  <= StIdle;
            end
         end
      end
   end

   assign o_VEN_n    = ~(w_vcul & w_hit);
   assign o_WD       = r_next;
   assign o_WDOE     = i_ONTRF & i_CWEN & (r_state == StGotA);
   assign o_OBJVALID = r_objvalid;
   assign o_HPOS     = r_out_hpos;
   assign o_FLIP     = r_out_flip;
   assign o_ADDR     = r_out_addr;
   assign o_SEQERR   = r_seqerr;

endmodule
